dual_bus_arbiter: RTL
=====================

Name: dual_bus_arbiter

Overview:
- Round-robin arbiter and address/data mux that shares the single external memory port between the two mips cores (m0, m1).
- Sits between the cores and extememory in place of a plain bus mux.
- Grants are registered and one-hot.
- Supports a per-core lock for atomic read-modify-write sequences.
- Counts contention events for debug display.

Parameters:
- WIDTH, 8, data/address bus width
- CNTBITS, 8, width of the contention counter

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- request  input  2  per-core bus request; bit n = memread_n | memwrite_n
- lock  input  2  per-core lock; while asserted with the grant held, the arbiter cannot release that core
- adr0  input  WIDTH  core 0 address
- adr1  input  WIDTH  core 1 address
- writedata0  input  WIDTH  core 0 write data
- writedata1  input  WIDTH  core 1 write data
- memwrite0  input  1  core 0 write strobe
- memwrite1  input  1  core 1 write strobe
- grant  output  2  one-hot registered grant
- adr  output  WIDTH  muxed address to memory
- writedata  output  WIDTH  muxed write data
- memwrite  output  1  muxed, grant-qualified write strobe
- owner  output  1  index of the last granted core
- contention  output  CNTBITS  saturating count of cycles in which both requests are high

Behaviour:
- Reset (synchronous, active-high, clk rising edge):
  - state=IDLE, grant=2'b00, owner=1 (so core 0 wins the first tie), contention=0.
  - Reset mid-grant drops grant to 00 on the next edge; no memwrite is issued that cycle.
- States: IDLE, GNT0, GNT1. Registers: state, owner, grant (grant decoded from state).
- IDLE:
  - request=01 -> GNT0.
  - request=10 -> GNT1.
  - request=11 -> grant the core != owner.
  - request=00 -> stay in IDLE.
- GNTn:
  - Stay while request[n] | lock[n].
  - On release, if the other core is requesting, go directly to the other GNT state with no idle bubble.
  - On release with no other request -> IDLE.
  - owner updates to n on every entry into GNTn.
- Latency:
  - A request asserted in cycle t gives grant in cycle t+1 if the bus is free.
  - On handover, the departing core's grant drops and the incoming core's grant rises on the same edge.
- Mux outputs are combinational from the registered grant:
  - grant=01: adr=adr0, writedata=writedata0, memwrite=memwrite0.
  - grant=10: adr=adr1, writedata=writedata1, memwrite=memwrite1.
  - grant=00: adr=0, writedata=0, memwrite=0.
- memwrite is never asserted for a non-granted core.
- grant is never 11; this is a verification assertion.
- lock is ignored for a core that does not hold the grant. Locking does not acquire the bus; lock with request=0 from IDLE does nothing.
- Simultaneous release and new request by the same core: the core drops request for at least one cycle to release. If it drops and re-raises while the other core waits, the other core wins, giving round-robin fairness.
- contention increments each cycle request==2'b11 and saturates at 2^CNTBITS-1, with no wrap.

Optional Feature:
- Macro ARB_TIMEOUT_EN; with it, parameter MAX_TENURE (default 16) and a tenure counter are added.
  - The counter clears on each grant entry and counts cycles in GNTn while the other core requests.
  - On reaching MAX_TENURE with lock[n]=0, the arbiter forces release: one IDLE cycle (grant=00), then grants the other core.
  - A locked holder is never preempted.
- Without the macro:
  - No counter exists.
  - A holder keeps the bus for as long as it requests.

Test Plan:
- Reset then request=01 at cycle 2 -> grant=01 at cycle 3, adr=adr0; hold 3 cycles; drop -> grant=00 next edge.
- request=11 from IDLE after reset -> grant=01 (owner was 1). Core 0 drops -> grant=10 on the next edge with no 00 cycle, owner=1, contention counts both-requesting cycles.
- Core 1 granted with memwrite1=1, core 0 asserting memwrite0=1, writedata0=8'hAA, writedata1=8'h55 -> memwrite=1, writedata=8'h55, adr=adr1.
- Core 0 holds lock=1, drops request while core 1 requests -> grant stays 01 until lock drops, then grant=10 next edge.
- Assert reset during GNT1 with memwrite1=1 -> next edge grant=00, memwrite=0, owner=1, contention=0.
- ARB_TIMEOUT_EN, MAX_TENURE=4: core 0 holds request with lock=0 while core 1 requests -> after 4 cycles grant=00 for one cycle, then grant=10. Repeat with lock0=1 -> no preemption.

Source files
------------

// File: rtl/dual_bus_arbiter.sv
// Round-robin arbiter and bus mux that shares one memory port between two cores, with per-core lock and a contention counter.
// Optional: define ARB_TIMEOUT_EN to add a MAX_TENURE limit that preempts an unlocked holder.
module dual_bus_arbiter #(
    parameter int WIDTH   = 8,
    parameter int CNTBITS = 8
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int MAX_TENURE = 16
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         request,
    input  logic [1:0]         lock,
    input  logic [WIDTH-1:0]   adr0,
    input  logic [WIDTH-1:0]   adr1,
    input  logic [WIDTH-1:0]   writedata0,
    input  logic [WIDTH-1:0]   writedata1,
    input  logic               memwrite0,
    input  logic               memwrite1,
    output logic [1:0]         grant,
    output logic [WIDTH-1:0]   adr,
    output logic [WIDTH-1:0]   writedata,
    output logic               memwrite,
    output logic               owner,
    output logic [CNTBITS-1:0] contention
);

    // state | meaning
    // IDLE  | bus free, grant=00
    // GNT0  | core 0 owns the bus
    // GNT1  | core 1 owns the bus
    typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

    state_t state_q, state_d;
    logic   preempt0, preempt1;

`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(MAX_TENURE + 1);
    logic [TW-1:0] tenure_q;

    // Release is forced on the cycle that completes MAX_TENURE contended cycles.
    assign preempt0 = (state_q == GNT0) && request[1] && !lock[0] &&
                      (tenure_q == TW'(MAX_TENURE - 1));
    assign preempt1 = (state_q == GNT1) && request[0] && !lock[1] &&
                      (tenure_q == TW'(MAX_TENURE - 1));

    always_ff @(posedge clk) begin
        if (reset || state_d != state_q) begin
            tenure_q <= '0;
        end else if ((state_q == GNT0 && request[1]) || (state_q == GNT1 && request[0])) begin
            tenure_q <= tenure_q + 1'b1;
        end
    end
`else
    assign preempt0 = 1'b0;
    assign preempt1 = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                case (request)
                    2'b01:   state_d = GNT0;
                    2'b10:   state_d = GNT1;
                    2'b11:   state_d = owner ? GNT0 : GNT1;
                    default: state_d = IDLE;
                endcase
            end
            GNT0: begin
                if (preempt0)                   state_d = IDLE;
                else if (request[0] || lock[0]) state_d = GNT0;
                else if (request[1])            state_d = GNT1;
                else                            state_d = IDLE;
            end
            GNT1: begin
                if (preempt1)                   state_d = IDLE;
                else if (request[1] || lock[1]) state_d = GNT1;
                else if (request[0])            state_d = GNT0;
                else                            state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            owner      <= 1'b1;
            contention <= '0;
        end else begin
            state_q <= state_d;
            if (state_d == GNT0)      owner <= 1'b0;
            else if (state_d == GNT1) owner <= 1'b1;
            if (request == 2'b11 && contention != {CNTBITS{1'b1}})
                contention <= contention + 1'b1;
        end
    end

    always_comb begin
        grant     = 2'b00;
        adr       = '0;
        writedata = '0;
        memwrite  = 1'b0;
        case (state_q)
            GNT0: begin
                grant     = 2'b01;
                adr       = adr0;
                writedata = writedata0;
                memwrite  = memwrite0;
            end
            GNT1: begin
                grant     = 2'b10;
                adr       = adr1;
                writedata = writedata1;
                memwrite  = memwrite1;
            end
            default: ;
        endcase
    end

endmodule
